pwm_decoder: RTL and testbench

- Receive-side counterpart of the audio PWM generator. Recovers the DATA_WIDTH-bit sample from a PWM waveform with frame length 2^DATA_WIDTH clocks, where the signal is high for `sample` clocks starting at the frame start.
- Used for loopback self-test of the audio path and for capturing externally generated PWM.
- Output is a valid/ready sample stream plus lock and overrun status.

---
 rtl/pwm_decoder.sv | 131 +++++++++++++
 tb/tb_pwm_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM-to-sample decoder: recovers a DATA_WIDTH-bit duty count per 2^DATA_WIDTH-clock frame.
// Optional majority glitch filter on the synchronized input: define PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  pwm_in,
   output logic [DATA_WIDTH-1:0] sample_data,
   output logic                  sample_valid,
   input  logic                  sample_ready,
   output logic                  locked,
   output logic                  overrun,
   input  logic                  overrun_clr
);

   localparam logic [DATA_WIDTH-1:0] LAST = '1;

   typedef enum logic {SEARCH, MEASURE} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_sync, s, s_prev_q, rise;
   logic [DATA_WIDTH-1:0]  tmo_q, cyc_q;
   logic [DATA_WIDTH:0]    hi_q, sum;
   logic [DATA_WIDTH-1:0]  result;
   logic                   start_frame, resync, publish;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
   end

   assign s_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_DECODER_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       maj_q;

   // 2-of-3 vote over the last three synchronized samples hides 1-cycle glitches
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q <= '0;
         maj_q  <= 1'b0;
      end else begin
         hist_q <= {hist_q[0], s_sync};
         maj_q  <= (s_sync & hist_q[0]) | (s_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
      end
   end

   assign s = maj_q;
`else
   assign s = s_sync;
`endif

   assign rise = s & ~s_prev_q;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= SEARCH;
      else        state_q <= state_d;
   end

   // next state: once a frame starts we never go back to SEARCH short of reset
   always_comb begin
      state_d = state_q;
      if (state_q == SEARCH && start_frame) state_d = MEASURE;
   end

   // cyc_q is the frame index of the sample currently on s; hi_q counts highs before it
   always_comb begin
      start_frame = 1'b0;
      resync      = 1'b0;
      publish     = 1'b0;
      case (state_q)
         SEARCH:  start_frame = rise || (tmo_q == LAST);
         MEASURE: begin
            if (rise && cyc_q != '0) resync  = 1'b1;
            else if (cyc_q == LAST)  publish = 1'b1;
         end
         default: ;
      endcase
   end

   assign sum    = hi_q + {{DATA_WIDTH{1'b0}}, s};
   assign result = sum[DATA_WIDTH] ? LAST : sum[DATA_WIDTH-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s_prev_q <= 1'b0;
         tmo_q    <= '0;
         cyc_q    <= '0;
         hi_q     <= '0;
      end else begin
         s_prev_q <= s;
         tmo_q    <= (state_q == SEARCH && !start_frame) ? tmo_q + 1'b1 : '0;
         if (start_frame || resync) begin
            // this cycle is index 0 of a new frame
            cyc_q <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            hi_q  <= {{DATA_WIDTH{1'b0}}, s};
         end else if (state_q == MEASURE) begin
            cyc_q <= cyc_q + 1'b1;
            hi_q  <= publish ? '0 : sum;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_data  <= '0;
         sample_valid <= 1'b0;
         locked       <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (resync)       locked <= 1'b0;
         else if (publish) locked <= 1'b1;

         if (publish) begin
            sample_data  <= result;
            sample_valid <= 1'b1;
         end else if (sample_ready) begin
            sample_valid <= 1'b0;
         end

         if (publish && sample_valid && !sample_ready) overrun <= 1'b1;
         else if (overrun_clr)                         overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed bench for pwm_decoder: a counter-based PWM generator drives the pin, checks go through chk.
`timescale 1ns/1ps
module tb_pwm_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       pwm_in;
   logic [7:0] sample_data;
   logic       sample_valid;
   logic       sample_ready;
   logic       locked;
   logic       overrun;
   logic       overrun_clr;

   int n_chk  = 0;
   int n_fail = 0;
   int gcnt   = 0;
   int duty   = 0;
   int glitch_at = -1;

   pwm_decoder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .pwm_in       (pwm_in),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .locked       (locked),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr)
   );

   always #5 clk = ~clk;

   // frame-aligned generator: high for `duty` clocks from counter 0, optional one-shot glitch
   always @(negedge clk) begin
      pwm_in = (gcnt < duty) || (gcnt == glitch_at);
      if (gcnt == glitch_at) glitch_at = -1;
      gcnt = (gcnt + 1) % 256;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 700 && !seen; i++) begin
         @(negedge clk);
         if (sample_valid) seen = 1'b1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
   endtask

   task automatic wait_gcnt(input int v);
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(posedge clk);
         if (gcnt == v) hit = 1'b1;
      end
      chk("gcnt_reached", 32'(hit), 32'd1);
   endtask

   initial begin
      int n;
      bit seen;
      reset        = 1'b0;
      sample_ready = 1'b1;
      overrun_clr  = 1'b0;
      tick(5);
      chk("rst_data",    32'(sample_data),  32'd0);
      chk("rst_valid",   32'(sample_valid), 32'd0);
      chk("rst_locked",  32'(locked),       32'd0);
      chk("rst_overrun", 32'(overrun),      32'd0);

      // constant low: only the SEARCH timeout can start a frame
      reset = 1'b1;
      wait_valid("tmo");
      chk("tmo_data",   32'(sample_data), 32'd0);
      chk("tmo_locked", 32'(locked),      32'd1);

      duty = 128;
      tick(800);
      wait_valid("d128");
      chk("d128_data",   32'(sample_data), 32'd128);
      chk("d128_locked", 32'(locked),      32'd1);
      n = 0;
      for (int i = 0; i < 1024; i++) begin
         @(negedge clk);
         if (i == 0) chk("d128_pulse1", 32'(sample_valid), 32'd0);
         if (sample_valid) n++;
      end
      chk("d128_pulses", 32'(n), 32'd4);

      duty = 255;
      tick(800);
      wait_valid("d255");
      chk("d255_data", 32'(sample_data), 32'd255);

      duty = 0;
      tick(800);
      wait_valid("d0");
      chk("d0_data",   32'(sample_data), 32'd0);
      chk("d0_locked", 32'(locked),      32'd1);

      // all-high frame counts 256 and saturates
      duty = 256;
      tick(800);
      wait_valid("sat");
      chk("sat_data", 32'(sample_data), 32'd255);

      duty = 64;
      tick(800);
      wait_valid("d64");
      chk("d64_data",   32'(sample_data), 32'd64);
      chk("d64_locked", 32'(locked),      32'd1);
      wait_gcnt(100);
      duty = 200;
      tick(20);
      chk("switch_unlocked", 32'(locked), 32'd0);
      tick(800);
      wait_valid("d200");
      chk("d200_data",   32'(sample_data), 32'd200);
      chk("d200_locked", 32'(locked),      32'd1);

      duty = 100;
      tick(800);
      sample_ready = 1'b0;
      wait_valid("ovr1");
      tick(2);
      chk("ovr_hold_valid", 32'(sample_valid), 32'd1);
      chk("ovr_not_yet",    32'(overrun),      32'd0);
      tick(300);
      chk("ovr_set",   32'(overrun),      32'd1);
      chk("ovr_valid", 32'(sample_valid), 32'd1);
      chk("ovr_data",  32'(sample_data),  32'd100);
      overrun_clr = 1'b1;
      tick(1);
      overrun_clr = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);
      sample_ready = 1'b1;
      tick(2);
      chk("ovr_drain", 32'(sample_valid), 32'd0);

      duty = 64;
      tick(800);
      chk("glitch_pre_locked", 32'(locked), 32'd1);
      glitch_at = 150;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(posedge clk);
         if (glitch_at == -1) seen = 1'b1;
      end
      chk("glitch_fired", 32'(seen), 32'd1);
      tick(10);
`ifdef PWM_DECODER_GLITCH_FILTER_EN
      chk("glitch_locked", 32'(locked), 32'd1);
`else
      chk("glitch_locked", 32'(locked), 32'd0);
`endif
      wait_valid("glitch");
      chk("glitch_data", 32'(sample_data), 32'd64);

      // mid-frame async reset with valid and overrun both set beforehand
      duty = 128;
      tick(800);
      sample_ready = 1'b0;
      tick(600);
      chk("prerst_overrun", 32'(overrun), 32'd1);
      wait_gcnt(190);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("midrst_data",    32'(sample_data),  32'd0);
      chk("midrst_valid",   32'(sample_valid), 32'd0);
      chk("midrst_locked",  32'(locked),       32'd0);
      chk("midrst_overrun", 32'(overrun),      32'd0);
      tick(3);
      reset = 1'b1;
      sample_ready = 1'b1;
      n = 0;
      seen = 1'b0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         @(negedge clk);
         n++;
         if (sample_valid) seen = 1'b1;
      end
      chk("postrst_seen",    32'(seen),     32'd1);
      chk("postrst_latency", 32'(n >= 259), 32'd1);
      chk("postrst_data",    32'(sample_data), 32'd128);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
